// File: rtl/spi_receiver.sv
// +----------------------------------------------------------------------------+
// | Module      : spi_receiver                                                 |
// | Description : SPI mode-0 peripheral receiver. Oversamples SCLK/SS/MOSI in  |
// |               the clk domain, assembles MSB-first bytes and buffers them   |
// |               in a first-word fall-through FIFO popped by the CPU.         |
// |               Optional echo of the previous byte on MISO when the macro    |
// |               SPI_RX_ECHO_EN is defined; otherwise MISO is tied low.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module spi_receiver #(
  parameter int BUFFER_SIZE = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           spi_clk,
  input  logic                           ss,
  input  logic                           mosi,
  output logic                           miso,
  input  logic                           read,
  output logic [7:0]                     value,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(BUFFER_SIZE):0]   count,
  output logic                           overrun,
  input  logic                           clear_ovr
);

  localparam int c_AW = $clog2(BUFFER_SIZE);
  localparam int c_PW = c_AW + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Synchroniser chains, edge-detect history and receiver state
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_sclk_hist;
  logic                   r_ss_hist;
  logic                   r_ss_armed;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shreg;

  // FIFO state
  logic [7:0]             r_mem [BUFFER_SIZE];
  logic [c_PW-1:0]        r_wr;
  logic [c_PW-1:0]        r_rd;
  logic                   r_empty;
  logic                   r_full;
  logic [c_PW-1:0]        r_count;
  logic                   r_overrun;

  logic                   w_sclk_s;
  logic                   w_ss_s;
  logic                   w_mosi_s;
  logic                   w_sclk_rise;
  logic                   w_ss_fall;
  logic                   w_ss_rise;
  logic                   w_start;
  logic                   w_push;
  logic [7:0]             w_byte;
  logic                   w_pop;
  logic                   w_wr_en;
  logic                   w_ovr_set;
  logic [c_PW-1:0]        w_wr_nxt;
  logic [c_PW-1:0]        w_rd_nxt;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_hist;
  assign w_ss_fall   = ~w_ss_s & r_ss_hist;
  assign w_ss_rise   = w_ss_s & ~r_ss_hist;
  // A frame may only start once SS has been genuinely seen high after reset,
  // so a select already low at reset release is ignored until it cycles.
  assign w_start     = (r_state == ST_IDLE) & w_ss_fall & r_ss_armed;
  assign w_byte      = {r_shreg[6:0], w_mosi_s};

  // Oversample the SPI pins and arm the receiver after a real SS-high sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_hist <= 1'b0;
      r_ss_hist   <= 1'b1;
      r_fill      <= '0;
      r_ss_armed  <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_hist <= w_sclk_s;
      r_ss_hist   <= w_ss_s;
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_ss_armed  <= r_ss_armed | (r_fill[SYNC_STAGES-1] & w_ss_s);
    end
  end

  // Receive FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Receive FSM next state and byte-complete strobe; SS rise beats a final bit
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_ss_rise) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sclk_rise && (r_bit_cnt == 3'd7)) begin
          w_push = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shift register and bit counter; the 3-bit counter wraps after bit 8
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= 3'd0;
      r_shreg   <= 8'h00;
    end else if (w_start) begin
      r_bit_cnt <= 3'd0;
    end else if ((r_state == ST_SHIFT) && !w_ss_rise && w_sclk_rise) begin
      r_shreg   <= w_byte;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

  // A pop only counts when data is present; a push into a full FIFO is
  // accepted only if a pop frees the slot in the same cycle.
  assign w_pop     = read & ~r_empty;
  assign w_wr_en   = w_push & (~r_full | w_pop);
  assign w_ovr_set = w_push & r_full & ~w_pop;
  assign w_wr_nxt  = r_wr + {{c_AW{1'b0}}, w_wr_en};
  assign w_rd_nxt  = r_rd + {{c_AW{1'b0}}, w_pop};

  // FIFO storage, not reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr[c_AW-1:0]] <= w_byte;
    end
  end

  // Pointers and flags registered from next-state pointers; overrun set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_empty <= (w_wr_nxt == w_rd_nxt);
      r_full  <= (w_wr_nxt[c_AW-1:0] == w_rd_nxt[c_AW-1:0]) &&
                 (w_wr_nxt[c_AW] != w_rd_nxt[c_AW]);
      r_count <= w_wr_nxt - w_rd_nxt;
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (clear_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign value   = r_empty ? 8'h00 : r_mem[r_rd[c_AW-1:0]];
  assign empty   = r_empty;
  assign full    = r_full;
  assign count   = r_count;
  assign overrun = r_overrun;

`ifdef SPI_RX_ECHO_EN
  logic       w_sclk_fall;
  logic [7:0] r_last;
  logic [7:0] r_tx;
  logic       r_miso;

  assign w_sclk_fall = ~w_sclk_s & r_sclk_hist;

  // Echo the previous completed byte MSB first; a fresh byte is loaded whole
  // so the following falling edge presents its bit 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 8'h00;
      r_tx   <= 8'h00;
      r_miso <= 1'b0;
    end else begin
      if (w_push) begin
        r_last <= w_byte;
      end
      if (r_state == ST_IDLE) begin
        if (w_start) begin
          r_miso <= r_last[7];
          r_tx   <= {r_last[6:0], 1'b0};
        end else begin
          r_miso <= 1'b0;
        end
      end else if (w_ss_rise) begin
        r_miso <= 1'b0;
      end else if (w_push) begin
        r_tx <= w_byte;
      end else if (w_sclk_fall) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
    end
  end

  assign miso = r_miso;
`else
  assign miso = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_receiver.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_receiver                                              |
// | Description : Directed self-checking bench for spi_receiver with a byte    |
// |               scoreboard queue. Echo checks follow SPI_RX_ECHO_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_spi_receiver;

  localparam int BS = 64;
  localparam int SS = 2;
  localparam int HP = 4;    // SCLK half period in clk cycles (clk/8)
`ifdef SPI_RX_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       read = 1'b0;
  logic       clear_ovr = 1'b0;
  logic       miso;
  logic [7:0] value;
  logic       empty;
  logic       full;
  logic [6:0] count;
  logic       overrun;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] cap;
  logic [7:0] cap1;

  spi_receiver #(.BUFFER_SIZE(BS), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .ss(ss), .mosi(mosi),
    .miso(miso), .read(read), .value(value), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .clear_ovr(clear_ovr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_miso"}, 32'(miso), 32'd0);
    chk({tag, "_value"}, 32'(value), 32'd0);
  endtask

  // Shift nb bits of d MSB first; optionally pop during the last bit's push cycle
  task automatic send_bits(input logic [7:0] d, input int nb, input bit pop_last,
                           output logic [7:0] c);
    logic [7:0] e;
    c = 8'h00;
    for (int i = 0; i < nb; i++) begin
      mosi = d[7-i];
      repeat (HP) @(negedge clk);
      c = {c[6:0], miso};
      spi_clk = 1'b1;
      if (pop_last && (i == nb - 1)) begin
        repeat (SS) @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("simul_pop_head", 32'(value), 32'(e));
        read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        repeat (HP - SS - 1) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    ss = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HP) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, output logic [7:0] c);
    frame_begin();
    send_bits(d, 8, 1'b0, c);
    frame_end();
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    e = sb.pop_front();
    chk({tag, "_value"}, 32'(value), 32'(e));
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    reset_chk("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Echo: frame 1 echoes 0x00, frame 2 echoes frame 1's byte (or 0 without echo)
    send_frame(8'h12, cap1);
    sb.push_back(8'h12);
    send_frame(8'h34, cap);
    sb.push_back(8'h34);
    chk("echo_frame1", 32'(cap1), 32'h00);
    chk("echo_frame2", 32'(cap), ECHO ? 32'h12 : 32'h00);
    chk("echo_count", 32'(count), 32'd2);
    pop_chk("echo_pop1");
    pop_chk("echo_pop2");

    // Single byte
    send_frame(8'hA5, cap);
    sb.push_back(8'hA5);
    chk("single_empty", 32'(empty), 32'd0);
    chk("single_count", 32'(count), 32'd1);
    pop_chk("single_pop");
    chk("single_empty_after", 32'(empty), 32'd1);
    chk("single_count_after", 32'(count), 32'd0);
    read = 1'b1;                    // pop while empty is ignored
    @(negedge clk);
    read = 1'b0;
    chk("empty_read_count", 32'(count), 32'd0);

    // Burst of BS+1 bytes without reads; the last one is dropped
    frame_begin();
    for (int b = 0; b <= BS; b++) begin
      send_bits(8'(b), 8, 1'b0, cap);
      if (b < BS) sb.push_back(8'(b));
    end
    frame_end();
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_overrun", 32'(overrun), 32'd1);
    chk("burst_count", 32'(count), 32'(BS));
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    chk("clear_ovr", 32'(overrun), 32'd0);
    for (int b = 0; b < BS; b++) pop_chk("burst_pop");
    chk("burst_drained", 32'(empty), 32'd1);

    // Full plus simultaneous pop on the push cycle of 0x77
    frame_begin();
    for (int b = 0; b < BS; b++) begin
      send_bits(8'(8'h80 + b), 8, 1'b0, cap);
      sb.push_back(8'(8'h80 + b));
    end
    frame_end();
    chk("refill_full", 32'(full), 32'd1);
    frame_begin();
    send_bits(8'h77, 8, 1'b1, cap);
    sb.push_back(8'h77);
    frame_end();
    chk("simul_overrun", 32'(overrun), 32'd0);
    chk("simul_count", 32'(count), 32'(BS));
    chk("simul_full", 32'(full), 32'd1);
    for (int b = 0; b < BS; b++) pop_chk("simul_drain");
    chk("simul_drained", 32'(empty), 32'd1);

    // Abort after 5 bits, then a clean frame
    frame_begin();
    send_bits(8'hFF, 5, 1'b0, cap);
    frame_end();
    chk("abort_empty", 32'(empty), 32'd1);
    chk("abort_count", 32'(count), 32'd0);
    send_frame(8'h3C, cap);
    sb.push_back(8'h3C);
    chk("after_abort_value", 32'(value), 32'h3C);
    chk("after_abort_count", 32'(count), 32'd1);

    // Reset mid-byte with 0x3C still buffered
    frame_begin();
    send_bits(8'h81, 4, 1'b0, cap);
    rst_n = 1'b0;
    #1;
    reset_chk("midbyte_reset");
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;                   // ss still low at release
    repeat (10) @(negedge clk);
    send_bits(8'h81, 8, 1'b0, cap);
    repeat (HP) @(negedge clk);
    chk("ss_low_at_release_empty", 32'(empty), 32'd1);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    send_frame(8'h81, cap);
    chk("post_reset_value", 32'(value), 32'h81);
    chk("post_reset_count", 32'(count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
